// File: rtl/seg_scan_decoder_if.sv
// Bus between a multiplexed active-low 7-segment display and its scan decoder.
// SEG_DEC_BLANK_EN adds the per-digit blank flags to the decoder side.
interface seg_scan_decoder_if;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        valid;
  logic        err;
`ifdef SEG_DEC_BLANK_EN
  logic [3:0]  blank;

  modport master (output seg, an, input value, valid, err, blank);
  modport slave  (input seg, an, output value, valid, err, blank);
`else
  modport master (output seg, an, input value, valid, err);
  modport slave  (input seg, an, output value, valid, err);
`endif
endinterface

// File: rtl/seg_scan_decoder.sv
// Scans a 4-digit active-low 7-segment bus, debounces each digit and publishes 16-bit frames.
// SEG_DEC_BLANK_EN: treat the all-off pattern as a legal blank digit and drive bus.blank.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  seg_scan_decoder_if.slave bus
);
  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

  logic [3:0]      an_s1_q, an_s2_q, an_prev_q;
  logic [0:6]      seg_s1_q, seg_s2_q, seg_prev_q;
  logic [RW-1:0]   run_q, run_d;
  logic            same, cap;
  logic [3:0]      sel;
  logic [4:0]      dec;
  logic [3:0][3:0] shad_q, shad_d;
  logic [3:0]      mask_q, mask_d, errb_q, errb_w, errb_d;
  logic [15:0]     value_q, value_d;
  logic            valid_q, valid_d, err_q, err_d;

  // Returns {undecodable, nibble}; patterns listed seg[0]..seg[6].
  function automatic logic [4:0] decode(input logic [0:6] p);
    case (p)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b1100000: decode = 5'h0B;
      7'b0110001: decode = 5'h0C;
      7'b1000010: decode = 5'h0D;
      7'b0110000: decode = 5'h0E;
      7'b0111000: decode = 5'h0F;
`ifdef SEG_DEC_BLANK_EN
      7'b1111111: decode = 5'h00;
`endif
      default:    decode = 5'h10;
    endcase
  endfunction

  // Capture only on the cycle the run first reaches the threshold.
  always_comb begin
    same  = (an_s2_q == an_prev_q) && (seg_s2_q == seg_prev_q);
    run_d = RW'(1);
    if (same) run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
    cap   = (run_d == RUN_MAX) && !(same && run_q == RUN_MAX) && $onehot(~an_s2_q);
    sel   = cap ? ~an_s2_q : 4'b0000;
    dec   = decode(seg_s2_q);
  end

  for (genvar i = 0; i < 4; i++) begin : g_dig
    assign shad_d[i] = sel[i] ? dec[3:0] : shad_q[i];
    assign errb_w[i] = sel[i] ? dec[4]   : errb_q[i];
  end

`ifdef SEG_DEC_BLANK_EN
  logic [3:0] blk_q, blk_d, blank_q, blank_d;
  logic       dec_blk;

  assign dec_blk = (seg_s2_q == 7'b1111111);
  for (genvar i = 0; i < 4; i++) begin : g_blk
    assign blk_d[i] = sel[i] ? dec_blk : blk_q[i];
  end
  assign blank_d = (valid_d) ? blk_d : blank_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_q   <= 4'b0000;
      blank_q <= 4'b0000;
    end else begin
      blk_q   <= blk_d;
      blank_q <= blank_d;
    end
  end

  assign bus.blank = blank_q;
`endif

  always_comb begin
    mask_d  = mask_q | sel;
    errb_d  = errb_w;
    value_d = value_q;
    err_d   = err_q;
    valid_d = 1'b0;
    // Frame completes: publish including the nibble captured this cycle.
    if (cap && mask_d == 4'b1111) begin
      value_d = shad_d;
      err_d   = |errb_w;
      valid_d = 1'b1;
      mask_d  = 4'b0000;
      errb_d  = 4'b0000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_s1_q    <= 4'b1111;
      an_s2_q    <= 4'b1111;
      an_prev_q  <= 4'b1111;
      seg_s1_q   <= 7'b1111111;
      seg_s2_q   <= 7'b1111111;
      seg_prev_q <= 7'b1111111;
      run_q      <= '0;
      shad_q     <= '0;
      mask_q     <= 4'b0000;
      errb_q     <= 4'b0000;
      value_q    <= 16'h0000;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      an_s1_q    <= bus.an;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
      seg_s1_q   <= bus.seg;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      run_q      <= run_d;
      shad_q     <= shad_d;
      mask_q     <= mask_d;
      errb_q     <= errb_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: frame table, directed corner sequences, random scan vs. a sample-history model.
module tb_seg_scan_decoder;
  localparam int N = 4;
  typedef logic [0:6] seg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_decoder_if bus();
  seg_scan_decoder #(.STABLE_CYCLES(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  localparam seg_t PATS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  typedef struct {
    logic [3:0][0:6] p;   // p[d] is the pattern shown on digit d
    logic [15:0]     v;
    logic            e;
    logic [3:0]      b;
  } frame_t;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount;
  logic [15:0] last_val;
  logic        last_err;
  logic [3:0]  last_blank;

  // Reference model state
  logic [10:0] pin_q[$];     // pins waiting to reach the sample point
  logic [10:0] hist[$];      // recent samples
  logic [3:0]  m_nib [4];
  logic [3:0]  m_errb, m_mask, m_blk;
  logic [15:0] exp_value;
  logic        exp_err, exp_valid;
  logic [3:0]  exp_blank;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void dec(input seg_t p, output logic [3:0] nib, output logic e, output logic b);
    nib = 4'h0; e = 1'b1; b = 1'b0;
    for (int k = 0; k < 16; k++)
      if (p == PATS[k]) begin nib = k[3:0]; e = 1'b0; end
`ifdef SEG_DEC_BLANK_EN
    if (p == 7'b1111111) begin e = 1'b0; b = 1'b1; end
`endif
  endfunction

  task automatic model_reset();
    pin_q = {11'h7FF, 11'h7FF};
    hist.delete();
    m_mask = 0; m_errb = 0; m_blk = 0;
    for (int k = 0; k < 4; k++) m_nib[k] = 0;
    exp_value = 0; exp_err = 0; exp_valid = 0; exp_blank = 0;
  endtask

  // One clock edge: the sample seen this cycle is the pin value from two cycles earlier.
  task automatic model_edge(input logic [3:0] a, input seg_t sg);
    logic [10:0] s;
    logic [3:0]  an_s, nib;
    logic        e, b, caught;
    int          L, idx;
    s = pin_q.pop_front();
    pin_q.push_back({a, sg});
    exp_valid = 1'b0;
    hist.push_back(s);
    if (hist.size() > N + 1) void'(hist.pop_front());
    L = hist.size();
    caught = 1'b0;
    if (L >= N) begin
      caught = 1'b1;
      for (int k = 0; k < N; k++) if (hist[L-1-k] != s) caught = 1'b0;
      if (L > N && hist[L-1-N] == s) caught = 1'b0;
    end
    an_s = s[10:7];
    if (caught && $countones(an_s) == 3) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (!an_s[k]) idx = k;
      dec(s[6:0], nib, e, b);
      m_nib[idx] = nib; m_errb[idx] = e; m_blk[idx] = b; m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin
        exp_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        exp_err   = |m_errb;
        exp_blank = m_blk;
        exp_valid = 1'b1;
        m_mask = 0; m_errb = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] a, input seg_t sg);
    bus.an = a; bus.seg = sg;
    @(negedge clk);
    chk("valid", int'(bus.valid), int'(exp_valid));
    chk("value", int'(bus.value), int'(exp_value));
    chk("err",   int'(bus.err),   int'(exp_err));
`ifdef SEG_DEC_BLANK_EN
    chk("blank", int'(bus.blank), int'(exp_blank));
    if (bus.valid) last_blank = bus.blank;
`endif
    if (bus.valid) begin vcount++; last_val = bus.value; last_err = bus.err; end
    @(posedge clk);
    if (rst) model_reset(); else model_edge(a, sg);
    #1;
  endtask

  task automatic show(input int d, input seg_t p, input int cyc);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    repeat (cyc) step(a, p);
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) step(4'hF, 7'b1111111);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(4'hF, 7'b1111111);
    rst = 1'b0;
  endtask

  frame_t frames [5];

  initial begin
    frames[0] = '{p: {PATS[1], PATS[2], PATS[3], PATS[4]}, v: 16'h1234, e: 1'b0, b: 4'b0000};
    frames[1] = '{p: {PATS[10], 7'b1110000, PATS[5], PATS[15]}, v: 16'hA05F, e: 1'b1, b: 4'b0000};
    frames[2] = '{p: {PATS[8], PATS[9], PATS[11], PATS[12]}, v: 16'h89BC, e: 1'b0, b: 4'b0000};
    frames[3] = '{p: {PATS[13], PATS[14], PATS[6], PATS[7]}, v: 16'hDE67, e: 1'b0, b: 4'b0000};
`ifdef SEG_DEC_BLANK_EN
    frames[4] = '{p: {7'b1111111, PATS[0], PATS[0], PATS[1]}, v: 16'h0001, e: 1'b0, b: 4'b1000};
`else
    frames[4] = '{p: {7'b1111111, PATS[0], PATS[0], PATS[1]}, v: 16'h0001, e: 1'b1, b: 4'b0000};
`endif
    last_blank = 0;
    bus.an = 4'hF; bus.seg = 7'b1111111;
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    model_reset();
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst value", int'(bus.value), 0);
    chk("rst valid", int'(bus.valid), 0);
    chk("rst err",   int'(bus.err),   0);
    @(posedge clk); model_edge(4'hF, 7'b1111111); #1;

    // Table of full frames, digits 3..0 each held 6 cycles
    for (int f = 0; f < 5; f++) begin
      vcount = 0;
      for (int d = 3; d >= 0; d--) show(d, frames[f].p[d], 6);
      idle(3);
      chk($sformatf("frame%0d vcount", f), vcount, 1);
      chk($sformatf("frame%0d value", f), int'(last_val), int'(frames[f].v));
      chk($sformatf("frame%0d err", f), int'(last_err), int'(frames[f].e));
`ifdef SEG_DEC_BLANK_EN
      chk($sformatf("frame%0d blank", f), int'(last_blank), int'(frames[f].b));
`endif
    end

    // Digit 0 toggling faster than the stability window never captures
    vcount = 0;
    for (int d = 3; d >= 1; d--) show(d, PATS[7], 6);
    for (int k = 0; k < 8; k++) show(0, (k % 2) ? PATS[8] : PATS[0], 2);
    chk("glitch no valid", vcount, 0);
    show(0, PATS[8], 6);
    idle(3);
    chk("glitch vcount", vcount, 1);
    chk("glitch value", int'(last_val), 16'h7778);

    // Multi-low and all-high anodes never capture
    vcount = 0;
    repeat (20) step(4'b0011, PATS[1]);
    repeat (20) step(4'b1111, PATS[2]);
    for (int d = 3; d >= 1; d--) show(d, PATS[5], 6);
    idle(3);
    chk("bad an no valid", vcount, 0);
    show(0, PATS[9], 6);
    idle(3);
    chk("bad an vcount", vcount, 1);
    chk("bad an value", int'(last_val), 16'h5559);

    // Reset mid-frame discards the partial frame
    vcount = 0;
    for (int d = 3; d >= 1; d--) show(d, PATS[12], 6);
    do_reset();
    show(0, PATS[1], 6);
    idle(3);
    chk("mid rst no valid", vcount, 0);
    chk("mid rst value", int'(bus.value), 0);
    for (int d = 3; d >= 0; d--) show(d, PATS[1], 6);
    idle(3);
    chk("mid rst vcount", vcount, 1);
    chk("mid rst frame", int'(last_val), 16'h1111);

    // Random scan, checked cycle by cycle against the model
    for (int r = 0; r < 300; r++) begin
      logic [3:0] a;
      seg_t       sg;
      int         hold;
      if ($urandom_range(0, 3) != 0) a = ~(4'b0001 << $urandom_range(0, 3));
      else a = 4'($urandom);
      if ($urandom_range(0, 2) != 0) sg = PATS[$urandom_range(0, 15)];
      else sg = 7'($urandom);
      hold = $urandom_range(1, 8);
      repeat (hold) step(a, sg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
